smc_wr_strobe_ctrl: RTL and testbench
=====================================

Name: smc_wr_strobe_ctrl

Overview:
Parametrised write-strobe generator for the static memory controller. Replaces the purely combinational per-lane gating of the write strobes with a registered timing sequencer. Each accepted write request drives a SETUP/STROBE/HOLD sequence, with programmable cycle counts and full- or half-cycle strobe width, onto NUM_LANES active-low byte write enables plus one active-low write strobe. Sits between the SMC transfer state machine and the external memory pads.

Parameters:
NUM_LANES, 4, number of byte lanes (width of smc_n_we and wr_be); legal 1..8
CNT_W, 4, width of each timing field; max phase length 2^CNT_W-1 (+1 for strobe)

Ports:
sys_clk  input  1  system clock, all state on rising edge
n_sys_reset  input  1  asynchronous active-low reset
wr_req  input  1  write request; sampled only when wr_busy=0
wr_be  input  NUM_LANES  active-high byte enables, captured with wr_req
r_full  input  1  1=full-cycle strobe, 0=half-cycle strobe; captured with wr_req
cfg_setup  input  CNT_W  setup cycles before strobe (0 = no setup phase)
cfg_strobe  input  CNT_W  strobe phase length minus one
cfg_hold  input  CNT_W  hold cycles after strobe (0 = no hold phase)
smc_n_we  output  NUM_LANES  byte write enables, active low, registered
smc_n_wr  output  1  write strobe, active low, registered
wr_busy  output  1  high from the cycle after acceptance through the final cycle of the transfer
wr_ack  output  1  one-cycle pulse in the final cycle of the transfer

Behaviour:
- Reset (async, asserted): state IDLE, counters 0, smc_n_we all 1, smc_n_wr=1, wr_busy=0, wr_ack=0.
- Reset asserted mid-transfer: strobes return high immediately without waiting for a clock edge. No wr_ack is issued. The transfer is lost.
- All outputs come from flops. Strobes must be glitch-free.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- Acceptance: in IDLE, wr_req=1 at edge k captures wr_be, r_full, cfg_setup, cfg_strobe and cfg_hold.
  - Next state is SETUP if cfg_setup!=0, else STROBE.
  - wr_busy=1 from cycle k+1.
  - Config or input changes after capture have no effect on the transfer in progress.
- SETUP: lasts cfg_setup cycles, then STROBE. Strobes are high throughout.
- STROBE: lasts cfg_strobe+1 cycles (minimum 1), then HOLD if cfg_hold!=0, else the transfer ends.
  - Full mode (r_full=1): smc_n_wr=0 and smc_n_we[i]=~wr_be[i] for every STROBE cycle.
  - Half mode (r_full=0): same levels, but only for the first ceil((cfg_strobe+1)/2) STROBE cycles. Strobes are high for the remainder of STROBE.
- HOLD: lasts cfg_hold cycles. Strobes are high throughout.
- End of transfer: wr_ack=1 for exactly one cycle, in the last cycle of HOLD (or the last STROBE cycle if cfg_hold=0).
  - If wr_req=1 at the edge that ends the ack cycle, the new request is accepted immediately (back-to-back, no idle bubble); wr_busy stays 1.
  - Otherwise the FSM returns to IDLE and wr_busy=0.
- wr_be all zero: smc_n_we stays all high, but smc_n_wr still pulses per mode (dummy write) and wr_ack still issues.
- Counter arithmetic: CNT_W-bit down-counter loaded at each phase entry. No wrap-around; maximum values (all ones) must produce the exact cycle counts above.
- wr_req while wr_busy=1 (other than in the ack cycle) is ignored. Requesters must hold wr_req until they see wr_ack.

Test Plan:
- Reset then idle: n_sys_reset low mid-STROBE -> smc_n_we=4'hF and smc_n_wr=1 immediately; wr_busy=0, no wr_ack after release.
- Full mode, setup=2, strobe=3, hold=1, wr_be=4'b0101 -> after 2 high cycles, smc_n_we=4'b1010 and smc_n_wr=0 for exactly 4 cycles; 1 hold cycle with wr_ack=1; total busy 7 cycles.
- Half mode, setup=0, strobe=4, hold=0, wr_be=4'hF -> smc_n_we=4'h0 for 3 cycles then high for 2; wr_ack in cycle 5.
- Back-to-back: wr_req held high across two transfers (setup=1, strobe=0, hold=1) -> wr_busy never drops; second SETUP starts the cycle after the first wr_ack; exactly 2 ack pulses.
- wr_be=0, full mode, strobe=1 -> smc_n_we stays 4'hF; smc_n_wr low for 2 cycles; wr_ack issued.
- Max fields with CNT_W=4 (15/15/15) and NUM_LANES=8 -> 15 setup + 16 strobe + 15 hold cycles; config changed mid-transfer has no effect.

Source files
------------

// File: rtl/smc_wr_strobe_ctrl_if.sv
`default_nettype none
// ============================================================================
// smc_wr_strobe_ctrl_if : write request/config bundle and pad strobe outputs
// Revision: 1.0
// ============================================================================
interface smc_wr_strobe_ctrl_if #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 4
);
  logic                 wr_req;
  logic [NUM_LANES-1:0] wr_be;
  logic                 r_full;
  logic [CNT_W-1:0]     cfg_setup;
  logic [CNT_W-1:0]     cfg_strobe;
  logic [CNT_W-1:0]     cfg_hold;
  logic [NUM_LANES-1:0] smc_n_we;
  logic                 smc_n_wr;
  logic                 wr_busy;
  logic                 wr_ack;

  modport master (
    output wr_req, wr_be, r_full, cfg_setup, cfg_strobe, cfg_hold,
    input  smc_n_we, smc_n_wr, wr_busy, wr_ack
  );

  modport slave (
    input  wr_req, wr_be, r_full, cfg_setup, cfg_strobe, cfg_hold,
    output smc_n_we, smc_n_wr, wr_busy, wr_ack
  );
endinterface
`default_nettype wire

// File: rtl/smc_wr_strobe_ctrl.sv
`default_nettype none
// ============================================================================
// smc_wr_strobe_ctrl : registered SETUP/STROBE/HOLD write-strobe sequencer
// Revision: 1.0
// ============================================================================
module smc_wr_strobe_ctrl #(
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 4
) (
  input wire                  sys_clk,
  input wire                  n_sys_reset,
  smc_wr_strobe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_LANES-1:0] be_q, be_d;
  logic                 full_q, full_d;
  logic [CNT_W-1:0]     strb_q, strb_d;
  logic [CNT_W-1:0]     hold_q, hold_d;
  logic [CNT_W-1:0]     thr_q, thr_d;
  logic [NUM_LANES-1:0] n_we_q, n_we_d;
  logic                 n_wr_q, n_wr_d;
  logic                 busy_q, busy_d;
  logic                 ack_q, ack_d;
  logic                 w_end;
  logic                 w_accept;
  logic                 w_on;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    be_d    = be_q;
    full_d  = full_q;
    strb_d  = strb_q;
    hold_d  = hold_q;
    thr_d   = thr_q;

    w_end    = ((state_q == S_STROBE) && (cnt_q == '0) && (hold_q == '0)) ||
               ((state_q == S_HOLD) && (cnt_q == '0));
    w_accept = bus.wr_req && ((state_q == S_IDLE) || w_end);

    case (state_q)
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = strb_q;
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          if (hold_q != '0) begin
            state_d = S_HOLD;
            cnt_d   = hold_q - C_ONE;
          end
        end else begin
          cnt_d = cnt_q - C_ONE;
        end
      end
      S_HOLD: begin
        if (cnt_q != '0) cnt_d = cnt_q - C_ONE;
      end
      default: ;
    endcase

    if (w_end) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end

    if (w_accept) begin
      be_d   = bus.wr_be;
      full_d = bus.r_full;
      strb_d = bus.cfg_strobe;
      hold_d = bus.cfg_hold;
      // Half-width strobe stays asserted while the down-counter is >= ceil(strobe/2).
      thr_d  = (bus.cfg_strobe >> 1) + CNT_W'(bus.cfg_strobe[0]);
      if (bus.cfg_setup != '0) begin
        state_d = S_SETUP;
        cnt_d   = bus.cfg_setup - C_ONE;
      end else begin
        state_d = S_STROBE;
        cnt_d   = bus.cfg_strobe;
      end
    end

    // Outputs are decoded from the next state so the pads change exactly on phase boundaries.
    w_on   = (state_d == S_STROBE) && (full_d || (cnt_d >= thr_d));
    n_wr_d = ~w_on;
    n_we_d = w_on ? ~be_d : '1;
    busy_d = (state_d != S_IDLE);
    ack_d  = ((state_d == S_STROBE) && (cnt_d == '0) && (hold_d == '0)) ||
             ((state_d == S_HOLD) && (cnt_d == '0));
  end

  always_ff @(posedge sys_clk or negedge n_sys_reset) begin
    if (!n_sys_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      be_q    <= '0;
      full_q  <= 1'b0;
      strb_q  <= '0;
      hold_q  <= '0;
      thr_q   <= '0;
      n_we_q  <= '1;
      n_wr_q  <= 1'b1;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      be_q    <= be_d;
      full_q  <= full_d;
      strb_q  <= strb_d;
      hold_q  <= hold_d;
      thr_q   <= thr_d;
      n_we_q  <= n_we_d;
      n_wr_q  <= n_wr_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.smc_n_we = n_we_q;
  assign bus.smc_n_wr = n_wr_q;
  assign bus.wr_busy  = busy_q;
  assign bus.wr_ack   = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_smc_wr_strobe_ctrl.sv
`default_nettype none
// ============================================================================
// tb_smc_wr_strobe_ctrl : scoreboard bench, per-cycle expected pad/status trace
// Revision: 1.0
// ============================================================================
module tb_smc_wr_strobe_ctrl;

  localparam int NL = 8;
  localparam int CW = 4;

  typedef struct packed {
    logic [NL-1:0] n_we;
    logic          n_wr;
    logic          busy;
    logic          ack;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acks   = 0;
  int   acks0    = 0;
  bit   chk_en   = 1'b0;

  smc_wr_strobe_ctrl_if #(.NUM_LANES(NL), .CNT_W(CW)) bus ();

  smc_wr_strobe_ctrl #(.NUM_LANES(NL), .CNT_W(CW)) dut (
    .sys_clk     (clk),
    .n_sys_reset (rst_n),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected trace built from phase lengths: setup, strobe+1, hold cycles.
  task automatic push_trace(input logic [NL-1:0] be, input bit full,
                            input int su, input int st, input int ho);
    int   total;
    bit   on;
    exp_t e;
    total = su + st + 1 + ho;
    for (int i = 0; i < total; i++) begin
      on     = (i >= su) && (i < su + st + 1) && (full || ((i - su) < (st + 2) / 2));
      e.n_we = on ? ~be : '1;
      e.n_wr = ~on;
      e.busy = 1'b1;
      e.ack  = (i == total - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic scramble();
    bus.wr_be      = NL'($urandom);
    bus.r_full     = ~bus.r_full;
    bus.cfg_setup  = CW'($urandom);
    bus.cfg_strobe = CW'($urandom);
    bus.cfg_hold   = CW'($urandom);
  endtask

  task automatic drive(input logic [NL-1:0] be, input bit full,
                       input int su, input int st, input int ho);
    bus.wr_be      = be;
    bus.r_full     = full;
    bus.cfg_setup  = CW'(su);
    bus.cfg_strobe = CW'(st);
    bus.cfg_hold   = CW'(ho);
    bus.wr_req     = 1'b1;
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_xfer(input logic [NL-1:0] be, input bit full,
                         input int su, input int st, input int ho);
    drive(be, full, su, st, ho);
    @(posedge clk);
    #1;
    push_trace(be, full, su, st, ho);
    bus.wr_req = 1'b0;
    scramble();
    wait_drain(200);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.wr_ack === 1'b1) n_acks++;
    if (chk_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e.n_we = '1;
        e.n_wr = 1'b1;
        e.busy = 1'b0;
        e.ack  = 1'b0;
      end
      check("n_we", 32'(bus.smc_n_we), 32'(e.n_we));
      check("n_wr", 32'(bus.smc_n_wr), 32'(e.n_wr));
      check("busy", 32'(bus.wr_busy),  32'(e.busy));
      check("ack",  32'(bus.wr_ack),   32'(e.ack));
    end
  end

  initial begin
    rst_n          = 1'b1;
    bus.wr_req     = 1'b0;
    bus.wr_be      = '0;
    bus.r_full     = 1'b0;
    bus.cfg_setup  = '0;
    bus.cfg_strobe = '0;
    bus.cfg_hold   = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_n_we", 32'(bus.smc_n_we), 32'hFF);
    check("rst_n_wr", 32'(bus.smc_n_wr), 32'd1);
    check("rst_busy", 32'(bus.wr_busy),  32'd0);
    check("rst_ack",  32'(bus.wr_ack),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    do_xfer(8'h05, 1'b1, 2, 3, 1);
    do_xfer(8'hFF, 1'b0, 0, 4, 0);

    // Back-to-back: request held through the first ack cycle
    acks0 = n_acks;
    drive(8'h3C, 1'b1, 1, 0, 1);
    @(posedge clk);
    #1;
    push_trace(8'h3C, 1'b1, 1, 0, 1);
    push_trace(8'h3C, 1'b1, 1, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    bus.wr_req = 1'b0;
    scramble();
    wait_drain(50);
    check("b2b_acks", 32'(n_acks - acks0), 32'd2);

    do_xfer(8'h00, 1'b1, 0, 1, 0);
    do_xfer(8'h81, 1'b0, 1, 1, 2);
    do_xfer(8'hA5, 1'b1, 15, 15, 15);
    do_xfer(8'h5A, 1'b0, 15, 15, 15);

    // Reset in the middle of STROBE
    acks0 = n_acks;
    drive(8'hFF, 1'b1, 1, 7, 2);
    @(posedge clk);
    #1;
    push_trace(8'hFF, 1'b1, 1, 7, 2);
    bus.wr_req = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_n_wr", 32'(bus.smc_n_wr), 32'd0);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("mid_rst_n_we", 32'(bus.smc_n_we), 32'hFF);
    check("mid_rst_n_wr", 32'(bus.smc_n_wr), 32'd1);
    check("mid_rst_busy", 32'(bus.wr_busy),  32'd0);
    check("mid_rst_ack",  32'(bus.wr_ack),   32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_ack", 32'(n_acks - acks0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
